// File: rtl/bin_qdi_pkg.sv
// bin_qdi_pkg
//   Shared definitions for the binary-to-QDI e1of4 transmitter:
//   - E1OF4_W : width of the e1of4 data rail bundle
//   - state_t : four-phase handshake sequencer states
//   - enc1of4 : 2-bit binary value to one-hot rail encoding
package bin_qdi_pkg;

  localparam int unsigned E1OF4_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RTZ
  } state_t;

  // 00->0001, 01->0010, 10->0100, 11->1000
  function automatic logic [E1OF4_W-1:0] enc1of4(input logic [1:0] v);
    logic [E1OF4_W-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_qdi_1of4_sync_ff.sv
// sync_ff
//   Generic multi-flop synchronizer with asynchronous active-low reset.
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset, clears the whole chain
//     d     : asynchronous input
//     q     : d delayed through STAGES flops
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/bin_to_qdi_1of4.sv
// bin_to_qdi_1of4
//   Transmitter from the clocked binary domain into a QDI circuit. 2-bit
//   tokens arrive on a valid/ready port, are buffered in a small FIFO, and
//   each is sent as one e1of4 token on R under a four-phase handshake with
//   the circuit's enable Re.
//   Ports:
//     CLK         : clock, all state updates on posedge
//     RESET       : asynchronous active-low reset
//     din         : binary token value
//     din_valid   : din holds a token
//     din_ready   : FIFO can accept (transfer on din_valid && din_ready)
//     R           : e1of4 data rails, one-hot or neutral, driven from a flop
//     Re          : asynchronous right enable from the circuit, 1 = request
//     busy        : FIFO non-empty or handshake not back in IDLE
//     tokens_sent : completed four-phase cycles, wraps mod 2^CNT_W
//     VDD, GND    : supply pins kept for netlist compatibility, unused
module bin_to_qdi_1of4
  import bin_qdi_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [E1OF4_W-1:0] R,
  input  logic               Re,
  output logic               busy,
  output logic [CNT_W-1:0]   tokens_sent,
  inout  wire                VDD,
  inout  wire                GND
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic unused_supply;
  assign unused_supply = VDD ^ GND;

  // Re synchronizer; the sequencer only ever looks at re_s
  logic re_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_re_sync (
    .clk  (CLK),
    .rst_n(RESET),
    .d    (Re),
    .q    (re_s)
  );

  // Token FIFO
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full, empty, push, pop;

  // Handshake sequencer
  state_t             state_q, state_d;
  logic [E1OF4_W-1:0] r_q, r_d;
  logic [CNT_W-1:0]   sent_q, sent_d;

  assign full      = (occ_q == OCC_W'(DEPTH));
  assign empty     = (occ_q == '0);
  // Gated by RESET so the port reads not-ready while reset is held
  assign din_ready = RESET && !full;
  assign push      = din_valid && din_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        r_d = '0;
        if (!empty && re_s) begin
          pop     = 1'b1;
          r_d     = enc1of4(mem_q[rd_ptr_q]);
          state_d = SEND;
        end
      end
      SEND: begin
        // Re_s still high just means the receiver has not latched yet
        if (!re_s) begin
          r_d     = '0;
          state_d = RTZ;
        end
      end
      RTZ: begin
        r_d = '0;
        if (re_s) begin
          sent_d  = sent_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        r_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= IDLE;
      r_q      <= '0;
      sent_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      r_q      <= r_d;
      sent_q   <= sent_d;
    end
  end

  assign R           = r_q;
  assign busy        = !empty || (state_q != IDLE);
  assign tokens_sent = sent_q;

  a_r_onehot0 : assert property (@(posedge CLK) disable iff (!RESET)
    $onehot0(r_q));

  a_r_stable_in_send : assert property (@(posedge CLK) disable iff (!RESET)
    (state_q == SEND && $past(state_q) == SEND) |-> (r_q == $past(r_q)));

endmodule

// File: tb/tb_bin_to_qdi_1of4.sv
// tb_bin_to_qdi_1of4
//   Scoreboard bench for bin_to_qdi_1of4: accepted tokens are queued with
//   their expected rail pattern, a receiver model drives Re, and a monitor
//   compares each new non-neutral R against the queue head.
module tb_bin_to_qdi_1of4;

  localparam int unsigned CNT_W = 4;

  logic             CLK;
  logic             RESET;
  logic [1:0]       din;
  logic             din_valid;
  logic             din_ready;
  logic [3:0]       R;
  logic             Re;
  logic             busy;
  logic [CNT_W-1:0] tokens_sent;
  wire              vdd = 1'b1;
  wire              gnd = 1'b0;

  bin_to_qdi_1of4 #(
    .DEPTH      (2),
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .R          (R),
    .Re         (Re),
    .busy       (busy),
    .tokens_sent(tokens_sent),
    .VDD        (vdd),
    .GND        (gnd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [1:0]  expq[$];
  int unsigned sent_exp = 0;
  int unsigned rx_mode = 1;  // 0 = auto receiver, 1 = hold Re high, 2 = hold Re low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural QDI receiver: acknowledges a valid token by dropping Re,
  // re-requests once R is neutral, with a random delay between steps.
  initial begin : receiver
    int unsigned dly;
    dly = 0;
    Re  = 1'b1;
    forever begin
      @(negedge CLK);
      if (rx_mode == 1) begin
        Re = 1'b1;
      end else if (rx_mode == 2) begin
        Re = 1'b0;
      end else if (dly != 0) begin
        dly--;
      end else if (Re && R != 4'b0000) begin
        Re  = 1'b0;
        dly = $urandom_range(0, 3);
      end else if (!Re && R == 4'b0000) begin
        Re  = 1'b1;
        dly = $urandom_range(0, 3);
      end
    end
  end

  // Monitor: every new token on R must follow neutral and match the queue head.
  initial begin : monitor
    logic [3:0] prev_r;
    logic [1:0] tok;
    logic [3:0] want;
    prev_r = 4'b0000;
    forever begin
      @(negedge CLK);
      if (R != prev_r && R != 4'b0000) begin
        if (prev_r != 4'b0000) begin
          tests++;
          fails++;
          $display("FAIL r_no_neutral: got %b after %b expected 0000 between tokens", R, prev_r);
        end
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL r_extra_token: got %b expected no token", R);
        end else begin
          tok  = expq.pop_front();
          want = 4'b0001 << tok;
          check("r_token", {28'd0, R}, {28'd0, want});
        end
      end
      prev_r = R;
    end
  end

  // Offers v at the current negedge and holds it until it is accepted.
  task automatic push(input logic [1:0] v);
    bit done;
    done      = 1'b0;
    din       = v;
    din_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      if (din_ready) begin
        @(posedge CLK);
        expq.push_back(v);
        sent_exp++;
        done = 1'b1;
      end
      @(negedge CLK);
    end
    din_valid = 1'b0;
    check("push_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge CLK);
      if (!busy && expq.size() == 0) done = 1'b1;
    end
    check("drain_idle", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_r_zero();
    for (int i = 0; i < 100 && R != 4'b0000; i++) @(negedge CLK);
    check("r_rtz", {28'd0, R}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    RESET     = 1'b0;
    din       = 2'b00;
    din_valid = 1'b0;
    rx_mode   = 1;
    repeat (3) @(negedge CLK);
    check("rst_R", {28'd0, R}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tokens", {28'd0, tokens_sent}, 32'd0);
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    check("post_rst_ready", {31'd0, din_ready}, 32'd1);
    check("post_rst_R", {28'd0, R}, 32'd0);

    // Single token, one-cycle latency from push to R
    push(2'b11);
    @(posedge CLK);
    #1;
    check("single_latency", {28'd0, R}, 32'h8);
    @(negedge CLK);
    rx_mode = 2;
    wait_r_zero();
    rx_mode = 1;
    wait_idle();
    check("single_tokens", {28'd0, tokens_sent}, 32'd1);

    // Back-to-back stream with the auto receiver
    rx_mode = 0;
    push(2'b00);
    push(2'b01);
    push(2'b10);
    push(2'b11);
    wait_idle();
    check("stream_tokens", {28'd0, tokens_sent}, 32'(sent_exp % 16));

    // Stall: Re held low, FIFO fills, third offer waits
    rx_mode = 2;
    repeat (5) @(negedge CLK);
    push(2'b00);
    push(2'b01);
    check("stall_full_ready", {31'd0, din_ready}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    din       = 2'b10;
    din_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      check("stall_R", {28'd0, R}, 32'd0);
      check("stall_ready", {31'd0, din_ready}, 32'd0);
    end
    rx_mode = 0;
    push(2'b10);
    wait_idle();
    check("stall_tokens", {28'd0, tokens_sent}, 32'(sent_exp % 16));

    // Random stream: pushes meet pops at varying occupancy
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      push(2'($urandom_range(0, 3)));
    end
    wait_idle();
    check("random_tokens", {28'd0, tokens_sent}, 32'(sent_exp % 16));

    // Reset in the middle of SEND
    rx_mode = 1;
    repeat (3) @(negedge CLK);
    push(2'b10);
    @(posedge CLK);
    #1;
    check("mid_send_R", {28'd0, R}, 32'h4);
    repeat (3) @(negedge CLK);
    check("send_holds_R", {28'd0, R}, 32'h4);
    #2;
    RESET = 1'b0;
    #1;
    check("async_rst_R", {28'd0, R}, 32'd0);
    check("async_rst_tokens", {28'd0, tokens_sent}, 32'd0);
    check("async_rst_ready", {31'd0, din_ready}, 32'd0);
    expq.delete();
    sent_exp = 0;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (10) @(negedge CLK);
    check("post_rst_R_neutral", {28'd0, R}, 32'd0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // Counter wrap: 17 tokens on a 4-bit counter
    rx_mode = 0;
    for (int i = 0; i < 17; i++) begin
      push(2'($urandom_range(0, 3)));
    end
    wait_idle();
    check("wrap_tokens", {28'd0, tokens_sent}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
